// File: rtl/fifo_to_between_pkg.sv
// Shared constants for the FIFO-to-link byte mover: FSM encodings and CRC8 parameters.
package fifo_to_between_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_LATCH     = 3'd2,
    S_CRC       = 3'd3,
    S_SEND      = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  localparam logic [7:0] CRC_POLY = 8'h07;
  localparam logic [7:0] CRC_INIT = 8'h00;

  // One serial CRC8 step, MSB-first, no reflection.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    return {crc[6:0], 1'b0} ^ (((crc[7] ^ bit_in) == 1'b1) ? CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/fifo_to_between_if.sv
// FIFO read port and parallel link handshake bundled between mover and environment.
interface fifo_to_between_if;
  logic       fifo_empty;
  logic       fifo_busy;
  logic [7:0] fifo_data;
  logic       fifo_re;
  logic       t0, t1, t2, t3, t4, t5, t6, t7;
  logic       tsent;
  logic       trecieve;

  modport master (
    input  fifo_empty, fifo_busy, fifo_data, trecieve,
    output fifo_re, t0, t1, t2, t3, t4, t5, t6, t7, tsent
  );

  modport slave (
    output fifo_empty, fifo_busy, fifo_data, trecieve,
    input  fifo_re, t0, t1, t2, t3, t4, t5, t6, t7, tsent
  );
endinterface

// File: rtl/fifo_to_between_crc8.sv
// Serial CRC8 engine: absorbs one message bit per enabled clock, never cleared between bytes.
module fifo_to_between_crc8
  import fifo_to_between_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic [7:0] crc_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_reg <= CRC_INIT;
    end else if (en) begin
      crc_reg <= crc8_step(crc_reg, bit_in);
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/fifo_to_between.sv
// Moves bytes from a FIFO to a parallel handshake link one at a time, keeping a running CRC8,
// a handshaken-byte count and sticky error flags.
module fifo_to_between
  import fifo_to_between_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 start,
  fifo_to_between_if.master    bus,
  output logic [7:0]           CRC,
  output logic [7:0]           byte_count,
  output logic [3:0]           error,
  output logic                 isFinish
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state_reg, state_next;
  logic [7:0]    byte_reg, byte_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic [7:0]    t_reg, t_next;
  logic [7:0]    byte_count_reg, byte_count_next;
  logic [2:0]    error_reg, error_next;
  logic          fifo_re;
  logic          crc_en;
  logic          crc_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      byte_reg       <= '0;
      bit_cnt_reg    <= '0;
      tmo_cnt_reg    <= '0;
      t_reg          <= '0;
      byte_count_reg <= '0;
      error_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      byte_reg       <= byte_next;
      bit_cnt_reg    <= bit_cnt_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      t_reg          <= t_next;
      byte_count_reg <= byte_count_next;
      error_reg      <= error_next;
    end
  end

  // With enable low every *_next keeps its register value, so the whole block freezes.
  always_comb begin
    state_next      = state_reg;
    byte_next       = byte_reg;
    bit_cnt_next    = bit_cnt_reg;
    tmo_cnt_next    = tmo_cnt_reg;
    t_next          = t_reg;
    byte_count_next = byte_count_reg;
    error_next      = error_reg;
    fifo_re         = 1'b0;
    crc_en          = 1'b0;
    crc_bit         = byte_reg[3'd7 - bit_cnt_reg];

    if (enable) begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            if (bus.fifo_empty) begin
              error_next[1] = 1'b1;
              state_next    = S_DONE;
            end else begin
              state_next = S_REQ;
            end
          end
        end
        S_REQ: begin
          if (!bus.fifo_empty && !bus.fifo_busy) begin
            fifo_re    = 1'b1;
            state_next = S_LATCH;
          end
        end
        S_LATCH: begin
          byte_next    = bus.fifo_data;
          bit_cnt_next = 3'd0;
          state_next   = S_CRC;
        end
        S_CRC: begin
          crc_en       = 1'b1;
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            t_next       = byte_reg;
            tmo_cnt_next = '0;
            state_next   = S_SEND;
          end
        end
        S_SEND: begin
          if (!bus.trecieve) begin
            tmo_cnt_next = '0;
            state_next   = S_WAIT_DONE;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            error_next[0] = 1'b1;
            state_next    = S_DONE;
          end else begin
            tmo_cnt_next = tmo_cnt_reg + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (bus.trecieve) begin
            byte_count_next = byte_count_reg + 8'd1;
            if (byte_count_reg == 8'hFF) begin
              error_next[2] = 1'b1;
            end
            state_next = bus.fifo_empty ? S_DONE : S_REQ;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            error_next[0] = 1'b1;
            state_next    = S_DONE;
          end else begin
            tmo_cnt_next = tmo_cnt_reg + 1'b1;
          end
        end
        S_DONE: begin
          state_next = S_DONE;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  fifo_to_between_crc8 u_crc8 (
    .clk    (clk),
    .reset  (reset),
    .en     (crc_en),
    .bit_in (crc_bit),
    .crc    (CRC)
  );

  assign bus.fifo_re = fifo_re;
  assign bus.tsent   = (state_reg == S_SEND);
  assign bus.t0      = t_reg[0];
  assign bus.t1      = t_reg[1];
  assign bus.t2      = t_reg[2];
  assign bus.t3      = t_reg[3];
  assign bus.t4      = t_reg[4];
  assign bus.t5      = t_reg[5];
  assign bus.t6      = t_reg[6];
  assign bus.t7      = t_reg[7];

  assign byte_count = byte_count_reg;
  assign error      = {1'b0, error_reg};
  assign isFinish   = (state_reg == S_DONE);

endmodule
